// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back stage merging ALU and LSU results onto the
// dispatcher's single register-file write port.
//
// Each source has a small FIFO. A source's candidate is its FIFO head, or its
// live input when the FIFO is empty (bypass). Round-robin picks one candidate
// per cycle. The chosen write is registered onto wb_wr_en / wb_rd / wb_wr_data.
//
// Ports
//   clk, rst                        clock; synchronous active-high reset
//   alu_valid/alu_rd/alu_data       ALU result input
//   alu_ready                       ALU FIFO not full (state only)
//   lsu_valid/lsu_rd/lsu_data       LSU result input
//   lsu_ready                       LSU FIFO not full (state only)
//   wb_wr_en/wb_rd/wb_wr_data       registered register-file write
//   wb_idle                         nothing queued, arriving or being written
//
// Optional build macro WB_ARBITER_STATS_EN adds these ports:
//   wb_conflict_count               saturating count of cycles where both sources competed
//   wb_backpressure                 a valid source is currently being held off

module wb_arbiter_fifo #(
    parameter int XLEN       = 32,
    parameter int RA_W       = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [RA_W-1:0] i_rd,
    input  logic [XLEN-1:0] i_data,
    output logic            o_empty,
    output logic            o_full,
    output logic [RA_W-1:0] o_head_rd,
    output logic [XLEN-1:0] o_head_data
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [RA_W-1:0]  r_mem_rd   [FIFO_DEPTH];
    logic [XLEN-1:0]  r_mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_cnt;

    assign o_empty     = (r_cnt == '0);
    assign o_full      = (r_cnt == CNT_W'(FIFO_DEPTH));
    assign o_head_rd   = r_mem_rd[r_rptr];
    assign o_head_data = r_mem_data[r_rptr];

    // Storage needs no reset: the count gates every read.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem_rd[r_wptr]   <= i_rd;
            r_mem_data[r_wptr] <= i_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PTR_W'(1);
            if (i_pop)  r_rptr <= r_rptr + PTR_W'(1);
            r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end
endmodule

module wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int NUM_REGS   = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int RA_W       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [RA_W-1:0] alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [RA_W-1:0] lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    output logic            wb_wr_en,
    output logic [RA_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_wr_data,
    output logic            wb_idle
`ifdef WB_ARBITER_STATS_EN
    ,
    output logic [31:0]     wb_conflict_count,
    output logic            wb_backpressure
`endif
);
    // Source index 0 = ALU, 1 = LSU.
    logic [1:0]            w_valid, w_ready, w_empty, w_full;
    logic [1:0]            w_has, w_grant, w_push, w_pop;
    logic [1:0][RA_W-1:0]  w_in_rd, w_head_rd, w_cand_rd;
    logic [1:0][XLEN-1:0]  w_in_data, w_head_data, w_cand_data;
    logic                  w_both;
    logic [RA_W-1:0]       w_sel_rd;
    logic [XLEN-1:0]       w_sel_data;

    logic                  r_wr_en;
    logic [RA_W-1:0]       r_rd;
    logic [XLEN-1:0]       r_wr_data;
    logic                  r_prefer_lsu;

    assign w_valid   = {lsu_valid, alu_valid};
    assign w_in_rd   = {lsu_rd, alu_rd};
    assign w_in_data = {lsu_data, alu_data};

    for (genvar s = 0; s < 2; s++) begin : g_src
        wb_arbiter_fifo #(
            .XLEN       (XLEN),
            .RA_W       (RA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .i_push      (w_push[s]),
            .i_pop       (w_pop[s]),
            .i_rd        (w_in_rd[s]),
            .i_data      (w_in_data[s]),
            .o_empty     (w_empty[s]),
            .o_full      (w_full[s]),
            .o_head_rd   (w_head_rd[s]),
            .o_head_data (w_head_data[s])
        );

        assign w_ready[s] = !w_full[s];
        // Head first keeps per-source order; bypass only when nothing is queued.
        assign w_has[s]       = !w_empty[s] || w_valid[s];
        assign w_cand_rd[s]   = w_empty[s] ? w_in_rd[s]   : w_head_rd[s];
        assign w_cand_data[s] = w_empty[s] ? w_in_data[s] : w_head_data[s];
        assign w_pop[s]       = w_grant[s] && !w_empty[s];
        // A bypassed input that wins is written directly and never stored.
        assign w_push[s]      = w_valid[s] && w_ready[s] && !(w_grant[s] && w_empty[s]);
    end

    assign w_both = &w_has;

    always_comb begin
        w_grant = w_has;
        if (w_both) w_grant = r_prefer_lsu ? 2'b10 : 2'b01;
    end

    assign w_sel_rd   = w_grant[1] ? w_cand_rd[1]   : w_cand_rd[0];
    assign w_sel_data = w_grant[1] ? w_cand_data[1] : w_cand_data[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en      <= 1'b0;
            r_rd         <= '0;
            r_wr_data    <= '0;
            r_prefer_lsu <= 1'b1;
        end else begin
            r_wr_en <= |w_grant;
            if (|w_grant) begin
                r_rd      <= w_sel_rd;
                // x0 still gets a write strobe so its scoreboard bit clears.
                r_wr_data <= (w_sel_rd == '0) ? '0 : w_sel_data;
            end
            // Pointer moves only on a real contest: favour the loser next time.
            if (w_both) r_prefer_lsu <= !w_grant[1];
        end
    end

    assign alu_ready  = w_ready[0];
    assign lsu_ready  = w_ready[1];
    assign wb_wr_en   = r_wr_en;
    assign wb_rd      = r_rd;
    assign wb_wr_data = r_wr_data;
    assign wb_idle    = (&w_empty) && !alu_valid && !lsu_valid && !r_wr_en;

`ifdef WB_ARBITER_STATS_EN
    logic [31:0] r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (rst)                                     r_conflict_cnt <= '0;
        else if (w_both && r_conflict_cnt != '1)     r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end

    assign wb_conflict_count = r_conflict_cnt;
    assign wb_backpressure   = (alu_valid && !alu_ready) || (lsu_valid && !lsu_ready);
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid, lsu_valid;
    logic [RA_W-1:0] alu_rd, lsu_rd;
    logic [XLEN-1:0] alu_data, lsu_data;
    logic            alu_ready, lsu_ready;
    logic            wb_wr_en, wb_idle;
    logic [RA_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_wr_data;
`ifdef WB_ARBITER_STATS_EN
    logic [31:0]     wb_conflict_count;
    logic            wb_backpressure;
`endif

    wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .lsu_valid  (lsu_valid),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .lsu_ready  (lsu_ready),
        .wb_wr_en   (wb_wr_en),
        .wb_rd      (wb_rd),
        .wb_wr_data (wb_wr_data),
        .wb_idle    (wb_idle)
`ifdef WB_ARBITER_STATS_EN
        ,
        .wb_conflict_count (wb_conflict_count),
        .wb_backpressure   (wb_backpressure)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            aq[$];
    ent_t            lq[$];
    bit              started = 0;
    bit              pref_lsu;
    logic            e_en;
    logic [RA_W-1:0] e_rd;
    logic [XLEN-1:0] e_data;
    logic [31:0]     e_cc;
    int              n_wr = 0;

    // An accepted arrival joins the back of its source queue; the write chosen
    // this cycle is taken from the queue fronts, so order per source is FIFO.
    always @(posedge clk) begin
        if (rst) begin
            aq.delete();
            lq.delete();
            pref_lsu = 1;
            e_en     = 0;
            e_rd     = '0;
            e_data   = '0;
            e_cc     = '0;
            started  = 1;
        end else if (started) begin
            bit   take_l, any;
            ent_t w;
            if (alu_valid && aq.size() < DEPTH) aq.push_back('{alu_rd, alu_data});
            if (lsu_valid && lq.size() < DEPTH) lq.push_back('{lsu_rd, lsu_data});
            any    = (aq.size() > 0) || (lq.size() > 0);
            take_l = (lq.size() > 0);
            if (aq.size() > 0 && lq.size() > 0) begin
                take_l   = pref_lsu;
                pref_lsu = !take_l;
                if (e_cc != 32'hFFFF_FFFF) e_cc = e_cc + 1;
            end
            e_en = any;
            if (any) begin
                w      = take_l ? lq.pop_front() : aq.pop_front();
                e_rd   = w.rd;
                e_data = (w.rd == 0) ? '0 : w.data;
            end
        end
    end

    // Single compare process: every cycle after reset has been seen.
    always @(negedge clk) begin
        if (started) begin
            chk("wr_en", wb_wr_en, e_en);
            chk("wb_rd", wb_rd, e_rd);
            chk("wb_wr_data", wb_wr_data, e_data);
            chk("alu_ready", alu_ready, aq.size() != DEPTH);
            chk("lsu_ready", lsu_ready, lq.size() != DEPTH);
            chk("wb_idle", wb_idle,
                aq.size() == 0 && lq.size() == 0 && !alu_valid && !lsu_valid && !e_en);
`ifdef WB_ARBITER_STATS_EN
            chk("conflict_count", wb_conflict_count, e_cc);
            chk("backpressure", wb_backpressure,
                (alu_valid && aq.size() == DEPTH) || (lsu_valid && lq.size() == DEPTH));
`endif
            if (wb_wr_en === 1'b1) n_wr++;
        end
    end

    // ---------------- stimulus ----------------
    int alu_stall, n_acc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
    endtask

    // Random sources that hold a payload until it is accepted.
    task automatic stream(input int n, input int pa, input int pl);
        bit a_acc = 0, l_acc = 0;
        for (int i = 0; i < n; i++) begin
            if (!alu_valid || a_acc) begin
                alu_valid = ($urandom_range(99) < pa);
                alu_rd    = RA_W'($urandom_range(31));
                alu_data  = $urandom;
            end
            if (!lsu_valid || l_acc) begin
                lsu_valid = ($urandom_range(99) < pl);
                lsu_rd    = RA_W'($urandom_range(31));
                lsu_data  = $urandom;
            end
            @(negedge clk);
            a_acc = alu_valid && alu_ready;
            l_acc = lsu_valid && lsu_ready;
            if (alu_valid && !alu_ready) alu_stall++;
            n_acc += int'(a_acc) + int'(l_acc);
            tick();
        end
    endtask

    initial begin
        clear_in();
        rst = 1;
        tick(); tick();
        rst = 0;
        @(negedge clk);
        chk("rst wr_en", wb_wr_en, 0);
        chk("rst rd", wb_rd, 0);
        chk("rst data", wb_wr_data, 0);
        chk("rst alu_ready", alu_ready, 1);
        chk("rst lsu_ready", lsu_ready, 1);
        chk("rst idle", wb_idle, 1);

        // single ALU result
        tick();
        alu_valid = 1; alu_rd = 5; alu_data = 32'hA5A5_0001;
        tick(); clear_in();
        @(negedge clk);
        chk("single en", wb_wr_en, 1);
        chk("single rd", wb_rd, 5);
        chk("single data", wb_wr_data, 32'hA5A5_0001);
        tick();
        @(negedge clk);
        chk("single en after", wb_wr_en, 0);
        chk("single idle", wb_idle, 1);

        // simultaneous: LSU first, then ALU
        tick();
        alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h22;
        tick(); clear_in();
        @(negedge clk);
        chk("simul1 rd", wb_rd, 4);
        chk("simul1 data", wb_wr_data, 32'h22);
        tick();
        @(negedge clk);
        chk("simul2 en", wb_wr_en, 1);
        chk("simul2 rd", wb_rd, 3);
        chk("simul2 data", wb_wr_data, 32'h11);
        tick();
        @(negedge clk);
        chk("simul alu_ready", alu_ready, 1);
        chk("simul idle", wb_idle, 1);

        // x0 write
        tick();
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hDEAD_BEEF;
        tick(); clear_in();
        @(negedge clk);
        chk("x0 en", wb_wr_en, 1);
        chk("x0 rd", wb_rd, 0);
        chk("x0 data", wb_wr_data, 0);

        // ALU burst against a streaming LSU must fill the ALU FIFO
        tick();
        alu_stall = 0; n_acc = 0;
        stream(12, 100, 100);
        chk("alu_ready dropped", alu_stall > 0, 1);

        // reset with full FIFOs and live inputs: everything is dropped
        rst = 1;
        tick();
        rst = 0; clear_in();
        @(negedge clk);
        chk("midrst en", wb_wr_en, 0);
        chk("midrst alu_ready", alu_ready, 1);
        chk("midrst idle", wb_idle, 1);
        for (int i = 0; i < 6; i++) tick();

`ifdef WB_ARBITER_STATS_EN
        stream(10, 100, 100);
        clear_in();
        chk("conflicts >= 10", wb_conflict_count >= 10, 1);
        force dut.r_conflict_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.r_conflict_cnt;
        e_cc = 32'hFFFF_FFFD;
        tick();
        stream(6, 100, 100);
        clear_in();
        @(negedge clk);
        chk("conflict saturate", wb_conflict_count, 32'hFFFF_FFFF);
        for (int i = 0; i < 12; i++) tick();
`endif

        // random traffic, then drain: every accepted result is written once
        n_acc = 0;
        n_wr  = 0;
        stream(1500, 60, 60);
        stream(1500, 90, 80);
        clear_in();
        for (int i = 0; i < 3 * DEPTH + 4; i++) tick();
        @(negedge clk);
        chk("all written", n_wr, n_acc);
        chk("final idle", wb_idle, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
